// File: rtl/reg_scoreboard.sv
// Register scoreboard for the pipelined Y86-64 core: per-register pending-write
// counters that hold decode back until every source operand has been written back.
module reg_scoreboard #(
  parameter int NREG  = 15,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  input  logic [3:0]      dst_e,
  input  logic [3:0]      dst_m,
  input  logic            ret_e_valid,
  input  logic [3:0]      ret_e_reg,
  input  logic            ret_m_valid,
  input  logic [3:0]      ret_m_reg,
  input  logic            flush,
  output logic [NREG-1:0] pending,
  output logic            stall,
  output logic [15:0]     stall_cnt,
  output logic            underflow_err
);

  // Two spare bits so counter + increment (up to 2) never wraps before the compare.
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt      [NREG];
  logic [CNT_W-1:0] w_cntNext  [NREG];
  logic [SW-1:0]    w_incReq   [NREG];
  logic [SW-1:0]    w_sum      [NREG];
  logic [SW-1:0]    w_dec      [NREG];
  logic             w_srcBusy;
  logic             w_dstOver;
  logic             w_fire;
  logic             w_underflow;
  logic [15:0]      r_stallCnt;
  logic             r_underflow;

  // RNONE (4'hF) never equals a register index, so it drops out of every match.
  always_comb begin
    w_srcBusy = 1'b0;
    w_dstOver = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_incReq[i] = SW'(dst_e == 4'(i)) + SW'(dst_m == 4'(i));
      if ((src_a == 4'(i) || src_b == 4'(i)) && r_cnt[i] != '0)
        w_srcBusy = 1'b1;
      if (SW'(r_cnt[i]) + w_incReq[i] > CNT_MAX)
        w_dstOver = 1'b1;
    end
  end

  assign issue_ready = rst_n & ~flush & ~w_srcBusy & ~w_dstOver;
  assign w_fire      = issue_valid & issue_ready;
  assign stall       = rst_n & issue_valid & ~issue_ready;

  always_comb begin
    w_underflow = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_sum[i] = SW'(r_cnt[i]) + (w_fire ? w_incReq[i] : '0);
      w_dec[i] = SW'(ret_e_valid && ret_e_reg == 4'(i)) +
                 SW'(ret_m_valid && ret_m_reg == 4'(i));
      w_cntNext[i] = CNT_W'(w_sum[i] - w_dec[i]);
      if (w_dec[i] > w_sum[i]) begin
        w_cntNext[i] = '0;
        w_underflow  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_stallCnt  <= '0;
      r_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= flush ? '0 : w_cntNext[i];
      if (stall && r_stallCnt != 16'hFFFF) r_stallCnt <= r_stallCnt + 16'd1;
      if (!flush && w_underflow) r_underflow <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) pending[i] = (r_cnt[i] != '0);
  end

  assign stall_cnt     = r_stallCnt;
  assign underflow_err = r_underflow;

endmodule
